spart_rx: RTL and testbench
===========================

# spart_rx

Receive half of the SPART serial port. Consumes the one-cycle 16x-oversample receive enable from the baud generator, detects start bits on the asynchronous `rxd` line, samples each bit at its midpoint and assembles LSB-first 8-bit frames. It presents the byte, a receive-data-available flag and error flags to the bus interface, which reads and clears them.

## Interface
Parameters:
- `OVERSAMPLE`, default 16: `rx_baud` ticks per bit; power of two, minimum 4.
- `DATA_BITS`, default 8: data bits per frame.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `rx_baud`  in  1  one-cycle enable at OVERSAMPLE x baud, from the baud generator.
- `rxd`  in  1  asynchronous serial input; idles high.
- `rd_en`  in  1  bus read of the receive buffer; clears `rda` and the error flags.
- `rx_data`  out  DATA_BITS  last received byte.
- `rda`  out  1  receive data available.
- `framing_err`  out  1  stop bit of the last loaded frame sampled low.
- `overrun_err`  out  1  a frame was loaded while `rda` was already set.
- `parity_err`  out  1  parity mismatch; present only with SPART_RX_PARITY_EN.

## Operation
- `rxd` passes through a two-flop synchronizer (`rxd_s`); both flops reset to 1.
- A tick counter of width log2(OVERSAMPLE) advances only on cycles where `rx_baud`=1. A bit counter tracks data bits.
- IDLE: when `rxd_s`=0, clear the tick counter and go to START. No `rx_baud` is required to leave IDLE.
- START: on the tick where the count reaches OVERSAMPLE/2-1, sample `rxd_s`. A 1 is a false start; return to IDLE. A 0 clears the tick counter and bit counter; go to DATA.
- DATA: on every OVERSAMPLE-th tick, shift `rxd_s` into bit DATA_BITS-1 of the shift register, right-shifting (LSB first). After DATA_BITS samples, go to STOP, or to PARITY when that feature is compiled in.
- STOP: on the OVERSAMPLE-th tick, sample the stop bit, then:
  - load `rx_data` from the shift register;
  - set `rda`=1;
  - set `framing_err`=~`rxd_s`;
  - set `overrun_err` if `rda` was 1 and `rd_en`=0 on that cycle;
  - return to IDLE.
- The return to IDLE happens at mid-stop-bit, so a back-to-back start bit is caught.
- Overrun: the new byte overwrites `rx_data`. `overrun_err` is sticky until `rd_en`.
- `rd_en` clears `rda`, `framing_err`, `overrun_err` and `parity_err`. If `rd_en` and a frame load occur on the same cycle, the load wins:
  - `rda`=1;
  - error flags take the new frame's values;
  - no overrun.
- `rd_en` while `rda`=0 has no effect.

## Timing
- Reset values: `rx_data`=0; `rda`, `framing_err`, `overrun_err`, `parity_err` all 0; state IDLE; counters 0.
- `rst` mid-frame aborts the frame immediately; the partial byte is discarded.
- Start detection lags the `rxd` falling edge by 2 cycles (synchronizer).
- Latency from start detection to `rda` is OVERSAMPLE/2 + DATA_BITS*OVERSAMPLE + OVERSAMPLE ticks: 152 for the defaults, 168 with parity. Add one additional OVERSAMPLE-tick bit period when SPART_RX_PARITY_EN is defined.
- Within a tick, the flags and `rx_data` update on the clock edge where the sampling `rx_baud` is high. They are visible the following cycle.
- All outputs are registered.

## Configuration
- SPART_RX_PARITY_EN defined: a PARITY state follows DATA and samples one bit after OVERSAMPLE ticks. Even parity is used. At the STOP load, `parity_err` = XOR of the data bits and the parity bit.
- SPART_RX_PARITY_EN undefined: no PARITY state and no `parity_err` port; the frame is 8N1.

## Structure
- Package `spart_pkg`:
  - `rx_state_t` enum {IDLE, START, DATA, PARITY, STOP};
  - default OVERSAMPLE and DATA_BITS constants, shared with the baud generator and the transmitter.
- Sub-module `sync_2ff`: generic two-flop synchronizer with a reset-value parameter, reused by other asynchronous inputs.

## Test plan
- Stimulus for all scenarios: `rx_baud` pulses every 4 cycles, giving 64 cycles per bit.
- Send 0xA5 with a valid stop bit -> `rx_data`=0xA5 and `rda`=1 exactly 152 ticks after start detection, errors 0. Then `rd_en` -> `rda`=0 next cycle, `rx_data` holds 0xA5.
- Drive `rxd` low for 16 cycles only -> sampled high at tick 7, back to IDLE, `rda` stays 0.
- Send 0x3C with the stop bit held low -> `rx_data`=0x3C, `rda`=1, `framing_err`=1.
- Send 0x11 then 0x22 back-to-back without `rd_en` -> `rx_data`=0x22, `overrun_err`=1. Repeat with `rd_en` on the exact load cycle of 0x22 -> `rda`=1, `overrun_err`=0.
- Assert `rst` mid-data of 0xFF, then send 0x5A -> only 0x5A is received, with no errors.
- With SPART_RX_PARITY_EN defined, send 0x07 with parity bit 0 -> `parity_err`=1. Send 0x07 with parity bit 1 -> `parity_err`=0.

Source files
------------

// File: rtl/spart_pkg.sv
// Shared SPART types and default frame geometry, common to the baud generator,
// the transmitter and the receiver.
package spart_pkg;

   localparam int SPART_OVERSAMPLE = 16;
   localparam int SPART_DATA_BITS  = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP
   } rx_state_t;

endpackage

// File: rtl/spart_rx_if.sv
// Receive-side bus of the SPART: baud enable, serial line, buffer read and status.
// parity_err exists only when SPART_RX_PARITY_EN is defined.
interface spart_rx_if #(
   parameter int DATA_BITS = 8
);
   logic                 rx_baud;
   logic                 rxd;
   logic                 rd_en;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rda;
   logic                 framing_err;
   logic                 overrun_err;
`ifdef SPART_RX_PARITY_EN
   logic                 parity_err;
`endif

   modport master (
      output rx_baud, rxd, rd_en,
`ifdef SPART_RX_PARITY_EN
      input  parity_err,
`endif
      input  rx_data, rda, framing_err, overrun_err
   );

   modport slave (
      input  rx_baud, rxd, rd_en,
`ifdef SPART_RX_PARITY_EN
      output parity_err,
`endif
      output rx_data, rda, framing_err, overrun_err
   );

endinterface

// File: rtl/spart_rx_sync_2ff.sv
// Generic two-flop synchronizer for asynchronous single-bit inputs; both flops
// reset to RESET_VAL so an idle line does not look active coming out of reset.
module sync_2ff #(
   parameter logic RESET_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic i_d,
   output logic o_q
);
   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_meta <= RESET_VAL;
         r_sync <= RESET_VAL;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/spart_rx.sv
// SPART receiver: oversampled start detect, mid-bit sampling, LSB-first frames.
// Optional even parity bit and parity_err flag under SPART_RX_PARITY_EN.
module spart_rx
   import spart_pkg::*;
#(
   parameter int OVERSAMPLE = SPART_OVERSAMPLE,
   parameter int DATA_BITS  = SPART_DATA_BITS
) (
   input  logic      clk,
   input  logic      rst,
   spart_rx_if.slave bus
);
   localparam int TW = $clog2(OVERSAMPLE);
   localparam int BW = $clog2(DATA_BITS + 1);
   localparam logic [TW-1:0] TICK_HALF = TW'(OVERSAMPLE / 2 - 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
   localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

   rx_state_t            r_state;
   rx_state_t            w_next;
   logic                 w_rxd_s;
   logic [TW-1:0]        r_tick;
   logic [BW-1:0]        r_bit;
   logic [DATA_BITS-1:0] r_shift;
   logic [DATA_BITS-1:0] r_rx_data;
   logic                 r_rda;
   logic                 r_fe;
   logic                 r_oe;
   logic                 w_mid_bit;
   logic                 w_end_bit;
   logic                 w_tick_clr;
   logic                 w_bit_clr;
   logic                 w_shift;
   logic                 w_load;
`ifdef SPART_RX_PARITY_EN
   logic                 r_par;
   logic                 r_pe;
   logic                 w_par_smp;
`endif

   sync_2ff #(.RESET_VAL(1'b1)) u_rxd_sync (
      .clk (clk),
      .rst (rst),
      .i_d (bus.rxd),
      .o_q (w_rxd_s)
   );

   assign w_mid_bit = bus.rx_baud && (r_tick == TICK_HALF);
   assign w_end_bit = bus.rx_baud && (r_tick == TICK_LAST);

   always_ff @(posedge clk) begin
      if (rst) r_state <= IDLE;
      else     r_state <= w_next;
   end

   always_comb begin
      w_next     = r_state;
      w_tick_clr = 1'b0;
      w_bit_clr  = 1'b0;
      w_shift    = 1'b0;
      w_load     = 1'b0;
`ifdef SPART_RX_PARITY_EN
      w_par_smp  = 1'b0;
`endif
      case (r_state)
         IDLE: begin
            if (!w_rxd_s) begin
               w_tick_clr = 1'b1;
               w_next     = START;
            end
         end
         START: begin
            if (w_mid_bit) begin
               if (w_rxd_s) begin
                  w_next = IDLE;
               end else begin
                  w_tick_clr = 1'b1;
                  w_bit_clr  = 1'b1;
                  w_next     = DATA;
               end
            end
         end
         DATA: begin
            if (w_end_bit) begin
               w_shift = 1'b1;
               if (r_bit == BIT_LAST) begin
`ifdef SPART_RX_PARITY_EN
                  w_next = PARITY;
`else
                  w_next = STOP;
`endif
               end
            end
         end
`ifdef SPART_RX_PARITY_EN
         PARITY: begin
            if (w_end_bit) begin
               w_par_smp = 1'b1;
               w_next    = STOP;
            end
         end
`endif
         // Leaving at mid-stop-bit leaves half a bit to catch a back-to-back start.
         STOP: begin
            if (w_end_bit) begin
               w_load = 1'b1;
               w_next = IDLE;
            end
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_tick    <= '0;
         r_bit     <= '0;
         r_shift   <= '0;
         r_rx_data <= '0;
         r_rda     <= 1'b0;
         r_fe      <= 1'b0;
         r_oe      <= 1'b0;
`ifdef SPART_RX_PARITY_EN
         r_par     <= 1'b0;
         r_pe      <= 1'b0;
`endif
      end else begin
         if (w_tick_clr)       r_tick <= '0;
         else if (bus.rx_baud) r_tick <= r_tick + 1'b1;

         if (w_bit_clr)    r_bit <= '0;
         else if (w_shift) r_bit <= r_bit + 1'b1;

         if (w_shift) r_shift <= {w_rxd_s, r_shift[DATA_BITS-1:1]};
`ifdef SPART_RX_PARITY_EN
         if (w_par_smp) r_par <= w_rxd_s;
`endif
         // A load on the same cycle as a read wins; the read then cancels any overrun.
         if (w_load) begin
            r_rx_data <= r_shift;
            r_rda     <= 1'b1;
            r_fe      <= ~w_rxd_s;
            r_oe      <= ~bus.rd_en & (r_rda | r_oe);
`ifdef SPART_RX_PARITY_EN
            r_pe      <= ^{r_shift, r_par};
`endif
         end else if (bus.rd_en && r_rda) begin
            r_rda <= 1'b0;
            r_fe  <= 1'b0;
            r_oe  <= 1'b0;
`ifdef SPART_RX_PARITY_EN
            r_pe  <= 1'b0;
`endif
         end
      end
   end

   assign bus.rx_data     = r_rx_data;
   assign bus.rda         = r_rda;
   assign bus.framing_err = r_fe;
   assign bus.overrun_err = r_oe;
`ifdef SPART_RX_PARITY_EN
   assign bus.parity_err  = r_pe;
`endif

endmodule

// File: tb/tb_spart_rx.sv
// Self-checking bench for spart_rx: frame table plus scoreboard keyed on the
// expected load tick; parity vectors are added when SPART_RX_PARITY_EN is defined.
module tb_spart_rx;

   localparam int OS      = 16;
   localparam int DB      = 8;
   localparam int BIT_CYC = 64;
`ifdef SPART_RX_PARITY_EN
   localparam int LAT = 168;
`else
   localparam int LAT = 152;
`endif

   typedef struct {
      logic [7:0] data;
      logic       stop;
      logic       par;
      bit         rd_before;
      bit         rd_at_load;
      int         gap;
      logic       rda_pre;
      logic       fe;
      logic       oe;
      logic       pe;
   } vec_t;

   typedef struct {
      logic [7:0] data;
      logic       rda_pre;
      logic       fe;
      logic       oe;
      logic       pe;
      int         load_tick;
      bit         rd_at_load;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic rd_main = 1'b0;
   logic rd_mon = 1'b0;
   int   tick_total = 0;
   int   n_tests = 0;
   int   n_fail = 0;
   exp_t sb[$];

   spart_rx_if #(.DATA_BITS(DB)) bus ();
   assign bus.rd_en = rd_main | rd_mon;

   spart_rx #(.OVERSAMPLE(OS), .DATA_BITS(DB)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   initial begin : baud_gen
      int ph;
      ph = 0;
      bus.rx_baud = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         ph = (ph + 1) % 4;
         bus.rx_baud = (ph == 0);
      end
   end

   always @(posedge clk) if (bus.rx_baud) tick_total <= tick_total + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   function automatic vec_t mk(input logic [7:0] d, input logic stop, input bit rdb,
                               input bit rdl, input int gap, input logic pre,
                               input logic fe, input logic oe);
      vec_t v;
      v.data = d;       v.stop = stop;     v.par = ^d;
      v.rd_before = rdb; v.rd_at_load = rdl; v.gap = gap;
      v.rda_pre = pre;  v.fe = fe;         v.oe = oe;  v.pe = 1'b0;
      return v;
   endfunction

   // Start detection is the third edge after rxd falls; the load lands LAT ticks later.
   task automatic send_frame(input vec_t v);
      exp_t e;
      bus.rxd = 1'b0;
      cycles(3);
      e.data = v.data;  e.rda_pre = v.rda_pre; e.fe = v.fe; e.oe = v.oe; e.pe = v.pe;
      e.rd_at_load = v.rd_at_load;
      e.load_tick = tick_total + LAT;
      sb.push_back(e);
      cycles(BIT_CYC - 3);
      for (int i = 0; i < DB; i++) begin
         bus.rxd = v.data[i];
         cycles(BIT_CYC);
      end
`ifdef SPART_RX_PARITY_EN
      bus.rxd = v.par;
      cycles(BIT_CYC);
`endif
      if (v.stop) begin
         bus.rxd = 1'b1;
         cycles(BIT_CYC);
      end else begin
         bus.rxd = 1'b0;
         cycles(48);
         bus.rxd = 1'b1;
         cycles(BIT_CYC - 48);
      end
      cycles(v.gap);
   endtask

   task automatic wait_drain(input int max);
      int n;
      n = 0;
      while (sb.size() > 0 && n < max) begin
         cycles(1);
         n++;
      end
      chk("drain_pending", 32'(sb.size()), 32'd0);
      sb.delete();
   endtask

   initial begin : monitor
      forever begin
         @(negedge clk);
         if (sb.size() > 0) begin
            if (bus.rx_baud && tick_total == sb[0].load_tick - 1) begin
               chk("pre_load_rda", 32'(bus.rda), 32'(sb[0].rda_pre));
               if (sb[0].rd_at_load) rd_mon = 1'b1;
            end else if (tick_total == sb[0].load_tick) begin
               rd_mon = 1'b0;
               chk("rx_data", 32'(bus.rx_data), 32'(sb[0].data));
               chk("rda", 32'(bus.rda), 32'd1);
               chk("framing_err", 32'(bus.framing_err), 32'(sb[0].fe));
               chk("overrun_err", 32'(bus.overrun_err), 32'(sb[0].oe));
`ifdef SPART_RX_PARITY_EN
               chk("parity_err", 32'(bus.parity_err), 32'(sb[0].pe));
`endif
               void'(sb.pop_front());
            end
         end
      end
   end

   initial begin : watchdog
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin : main
      vec_t v;
      vec_t vecs[$];

      vecs.push_back(mk(8'h3C, 1'b0, 1'b0, 1'b0, 10, 1'b0, 1'b1, 1'b0));
      vecs.push_back(mk(8'h11, 1'b1, 1'b1, 1'b0, 0,  1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(8'h22, 1'b1, 1'b0, 1'b0, 10, 1'b1, 1'b0, 1'b1));
      vecs.push_back(mk(8'h11, 1'b1, 1'b1, 1'b0, 0,  1'b0, 1'b0, 1'b0));
      vecs.push_back(mk(8'h22, 1'b1, 1'b0, 1'b1, 10, 1'b1, 1'b0, 1'b0));
`ifdef SPART_RX_PARITY_EN
      v = mk(8'h07, 1'b1, 1'b1, 1'b0, 10, 1'b0, 1'b0, 1'b0);
      v.par = 1'b0; v.pe = 1'b1;
      vecs.push_back(v);
      v = mk(8'h07, 1'b1, 1'b1, 1'b0, 10, 1'b0, 1'b0, 1'b0);
      v.par = 1'b1; v.pe = 1'b0;
      vecs.push_back(v);
`endif

      bus.rxd = 1'b1;
      rst = 1'b1;
      cycles(4);
      rst = 1'b0;
      cycles(1);
      chk("reset_rx_data", 32'(bus.rx_data), 32'd0);
      chk("reset_rda", 32'(bus.rda), 32'd0);
      chk("reset_framing", 32'(bus.framing_err), 32'd0);
      chk("reset_overrun", 32'(bus.overrun_err), 32'd0);

      // 0xA5, exact latency, then a read
      send_frame(mk(8'hA5, 1'b1, 1'b0, 1'b0, 20, 1'b0, 1'b0, 1'b0));
      wait_drain(300);
      rd_main = 1'b1;
      cycles(1);
      rd_main = 1'b0;
      chk("read_clears_rda", 32'(bus.rda), 32'd0);
      chk("read_holds_data", 32'(bus.rx_data), 32'hA5);

      // 16-cycle glitch is a false start
      bus.rxd = 1'b0;
      cycles(16);
      bus.rxd = 1'b1;
      cycles(200);
      chk("false_start_rda", 32'(bus.rda), 32'd0);
      chk("false_start_data", 32'(bus.rx_data), 32'hA5);

      for (int i = 0; i < vecs.size(); i++) begin
         if (vecs[i].rd_before) begin
            rd_main = 1'b1;
            cycles(1);
            rd_main = 1'b0;
            cycles(1);
         end
         send_frame(vecs[i]);
      end
      wait_drain(400);

      // reset in the middle of 0xFF's data bits
      bus.rxd = 1'b0;
      cycles(BIT_CYC);
      bus.rxd = 1'b1;
      cycles(3 * BIT_CYC);
      rst = 1'b1;
      cycles(2);
      rst = 1'b0;
      cycles(1);
      chk("midframe_rst_rda", 32'(bus.rda), 32'd0);
      chk("midframe_rst_data", 32'(bus.rx_data), 32'd0);
      cycles(8 * BIT_CYC);
      chk("aborted_frame_rda", 32'(bus.rda), 32'd0);
      send_frame(mk(8'h5A, 1'b1, 1'b0, 1'b0, 10, 1'b0, 1'b0, 1'b0));
      wait_drain(300);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
